// File: rtl/window_fetch_reader_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// window_fetch_reader_pkg : shared frame geometry, state encoding, window layout
// Rev 1.0
// ----------------------------------------------------------------------------
package window_fetch_reader_pkg;

  localparam int DEF_IMWIDTH  = 240;
  localparam int DEF_IMHEIGHT = 180;
  localparam int DEF_ADDR_W   = 8;

  localparam int WIN_BITS   = 9;
  localparam int CENTRE_BIT = 4;
  localparam int K_W        = 4;

  localparam int STATE_W = 3;
  localparam logic [STATE_W-1:0] S_IDLE    = 3'd0;
  localparam logic [STATE_W-1:0] S_FETCH   = 3'd1;
  localparam logic [STATE_W-1:0] S_DRAIN   = 3'd2;
  localparam logic [STATE_W-1:0] S_PRESENT = 3'd3;
  localparam logic [STATE_W-1:0] S_DONE    = 3'd4;

  localparam logic [K_W-1:0] LAST_K = 4'd8;

endpackage
`default_nettype wire

// File: rtl/window_fetch_reader_neighbour_addr_gen.sv
`default_nettype none
// ----------------------------------------------------------------------------
// neighbour_addr_gen : maps centre + neighbour index k to a clamped (x, y, oob)
// Rev 1.0
// ----------------------------------------------------------------------------
module neighbour_addr_gen
  import window_fetch_reader_pkg::*;
#(
  parameter int IMWIDTH  = DEF_IMWIDTH,
  parameter int IMHEIGHT = DEF_IMHEIGHT,
  parameter int ADDR_W   = DEF_ADDR_W
) (
  input  logic [ADDR_W-1:0] centreX,
  input  logic [ADDR_W-1:0] centreY,
  input  logic [K_W-1:0]    k,
  output logic [ADDR_W-1:0] nbrX,
  output logic [ADDR_W-1:0] nbrY,
  output logic              oob
);

  localparam logic signed [ADDR_W:0] c_neg  = '1;
  localparam logic signed [ADDR_W:0] c_zero = '0;
  localparam logic signed [ADDR_W:0] c_pos  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]        c_w    = (ADDR_W+1)'(IMWIDTH);
  localparam logic [ADDR_W:0]        c_h    = (ADDR_W+1)'(IMHEIGHT);

  logic signed [ADDR_W:0] w_dx;
  logic signed [ADDR_W:0] w_dy;
  logic signed [ADDR_W:0] w_sx;
  logic signed [ADDR_W:0] w_sy;

  // k = (dy+1)*3 + (dx+1)
  always_comb begin
    w_dx = c_zero;
    w_dy = c_zero;
    case (k)
      4'd0, 4'd3, 4'd6: w_dx = c_neg;
      4'd2, 4'd5, 4'd8: w_dx = c_pos;
      default:          w_dx = c_zero;
    endcase
    if (k < 4'd3)      w_dy = c_neg;
    else if (k > 4'd5) w_dy = c_pos;
  end

  assign w_sx = $signed({1'b0, centreX}) + w_dx;
  assign w_sy = $signed({1'b0, centreY}) + w_dy;

  assign oob  = w_sx[ADDR_W] || w_sy[ADDR_W] ||
                ($unsigned(w_sx) >= c_w) || ($unsigned(w_sy) >= c_h);
  assign nbrX = oob ? centreX : w_sx[ADDR_W-1:0];
  assign nbrY = oob ? centreY : w_sy[ADDR_W-1:0];

endmodule
`default_nettype wire

// File: rtl/window_fetch_reader.sv
`default_nettype none
// ----------------------------------------------------------------------------
// window_fetch_reader : raster-scans the frame memory, presents 3x3 windows
// Rev 1.0
// ----------------------------------------------------------------------------
module window_fetch_reader
  import window_fetch_reader_pkg::*;
#(
  parameter int IMWIDTH  = DEF_IMWIDTH,
  parameter int IMHEIGHT = DEF_IMHEIGHT,
  parameter int ADDR_W   = DEF_ADDR_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W-1:0]   mem_x,
  output logic [ADDR_W-1:0]   mem_y,
  output logic                mem_write,
  input  logic                mem_data,
  output logic [WIN_BITS-1:0] win_data,
  output logic [ADDR_W-1:0]   win_x,
  output logic [ADDR_W-1:0]   win_y,
  output logic                win_valid,
  input  logic                win_ready
);

  localparam logic [ADDR_W-1:0] c_lastX = ADDR_W'(IMWIDTH - 1);
  localparam logic [ADDR_W-1:0] c_lastY = ADDR_W'(IMHEIGHT - 1);

  logic [STATE_W-1:0]  r_state;
  logic [STATE_W-1:0]  w_stateNext;
  logic [ADDR_W-1:0]   r_cx;
  logic [ADDR_W-1:0]   r_cy;
  logic [ADDR_W-1:0]   r_memX;
  logic [ADDR_W-1:0]   r_memY;
  logic [K_W-1:0]      r_k;
  logic [K_W-1:0]      r_capK;
  logic                r_capEn;
  logic                r_capOob;
  logic [WIN_BITS-1:0] r_win;
  logic [ADDR_W-1:0]   w_nbrX;
  logic [ADDR_W-1:0]   w_nbrY;
  logic                w_oob;
  logic                w_accept;
  logic                w_lastPixel;

  neighbour_addr_gen #(
    .IMWIDTH  (IMWIDTH),
    .IMHEIGHT (IMHEIGHT),
    .ADDR_W   (ADDR_W)
  ) u_nbrGen (
    .centreX (r_cx),
    .centreY (r_cy),
    .k       (r_k),
    .nbrX    (w_nbrX),
    .nbrY    (w_nbrY),
    .oob     (w_oob)
  );

  assign w_accept    = (r_state == S_PRESENT) && win_ready;
  assign w_lastPixel = (r_cx == c_lastX) && (r_cy == c_lastY);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      S_IDLE:    if (start) w_stateNext = S_FETCH;
      S_FETCH:   if (r_k == LAST_K) w_stateNext = S_DRAIN;
      S_DRAIN:   w_stateNext = S_PRESENT;
      S_PRESENT: if (win_ready) w_stateNext = w_lastPixel ? S_DONE : S_FETCH;
      S_DONE:    w_stateNext = S_IDLE;
      default:   w_stateNext = S_IDLE;
    endcase
  end

  // The address port is live only during FETCH; otherwise it parks on the last issue.
  always_comb begin
    busy      = (r_state == S_FETCH) || (r_state == S_DRAIN) || (r_state == S_PRESENT);
    done      = (r_state == S_DONE);
    win_valid = (r_state == S_PRESENT);
    mem_write = 1'b0;
    mem_x     = r_memX;
    mem_y     = r_memY;
    if (r_state == S_FETCH) begin
      mem_x = w_nbrX;
      mem_y = w_nbrY;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cx     <= '0;
      r_cy     <= '0;
      r_memX   <= '0;
      r_memY   <= '0;
      r_k      <= '0;
      r_capK   <= '0;
      r_capEn  <= 1'b0;
      r_capOob <= 1'b0;
      r_win    <= '0;
    end else begin
      // Memory read data trails the issued address by one cycle.
      r_capEn  <= (r_state == S_FETCH);
      r_capK   <= r_k;
      r_capOob <= w_oob;
      if (r_capEn) r_win[r_capK] <= r_capOob ? 1'b0 : mem_data;

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_cx <= '0;
            r_cy <= '0;
            r_k  <= '0;
          end
        end
        S_FETCH: begin
          r_memX <= w_nbrX;
          r_memY <= w_nbrY;
          r_k    <= (r_k == LAST_K) ? '0 : r_k + 4'd1;
        end
        S_PRESENT: begin
          if (w_accept && !w_lastPixel) begin
            if (r_cx == c_lastX) begin
              r_cx <= '0;
              r_cy <= r_cy + 1'b1;
            end else begin
              r_cx <= r_cx + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign win_data = r_win;
  assign win_x    = r_cx;
  assign win_y    = r_cy;

endmodule
`default_nettype wire

// File: tb/tb_window_fetch_reader.sv
`default_nettype none
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// tb_window_fetch_reader : directed bench on a 4x3 frame with a memory model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_window_fetch_reader;
  import window_fetch_reader_pkg::*;

  localparam int W  = 4;
  localparam int H  = 3;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          win_ready = 1'b0;
  logic          mem_data;
  logic          busy, done, mem_write, win_valid;
  logic [AW-1:0] mem_x, mem_y, win_x, win_y;
  logic [8:0]    win_data;

  window_fetch_reader #(.IMWIDTH(W), .IMHEIGHT(H), .ADDR_W(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .mem_x     (mem_x),
    .mem_y     (mem_y),
    .mem_write (mem_write),
    .mem_data  (mem_data),
    .win_data  (win_data),
    .win_x     (win_x),
    .win_y     (win_y),
    .win_valid (win_valid),
    .win_ready (win_ready)
  );

  always #5 clk = ~clk;

  logic memArr [0:W*H-1];
  always @(posedge clk)
    mem_data <= (int'(mem_x) < W && int'(mem_y) < H) ? memArr[int'(mem_y)*W + int'(mem_x)] : 1'b0;

  int         nChecks = 0;
  int         nFails = 0;
  int         winCount = 0;
  int         doneCount = 0;
  bit         memWriteSeen = 1'b0;
  logic [8:0] winRec [0:W*H-1];

  // Observes the values the DUT will sample at the coming rising edge.
  always begin
    @(negedge clk);
    #1;
    if (mem_write !== 1'b0) memWriteSeen = 1'b1;
    if (reset) begin
      if (done) doneCount++;
      if (win_valid && win_ready) begin
        winCount++;
        if (int'(win_x) < W && int'(win_y) < H) winRec[int'(win_y)*W + int'(win_x)] = win_data;
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    nChecks++;
    if (act != exp) begin
      nFails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic setMem(input int pat);
    for (int i = 0; i < W*H; i++) memArr[i] = (pat == 0) ? 1'b1 : (i == 1*W + 2);
  endtask

  function automatic void nbr(input int cx, input int cy, input int k, output int nx, output int ny);
    nx = cx + (k % 3) - 1;
    ny = cy + (k / 3) - 1;
    if (nx < 0 || ny < 0 || nx >= W || ny >= H) begin
      nx = cx;
      ny = cy;
    end
  endfunction

  function automatic logic [8:0] modelWin(input int cx, input int cy);
    logic [8:0] r;
    int nx, ny;
    r = '0;
    for (int k = 0; k < 9; k++) begin
      nx = cx + (k % 3) - 1;
      ny = cy + (k / 3) - 1;
      if (nx >= 0 && ny >= 0 && nx < W && ny < H) r[k] = memArr[ny*W + nx];
    end
    return r;
  endfunction

  task automatic waitValid(input int budget, output int cyc);
    cyc = 0;
    while (!win_valid && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    if (!win_valid) begin
      nChecks++;
      nFails++;
      $display("FAIL win_valid_timeout: got 0, expected 1 within %0d cycles", budget);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    check({tag, "_busy"},      int'(busy), 0);
    check({tag, "_done"},      int'(done), 0);
    check({tag, "_win_valid"}, int'(win_valid), 0);
    check({tag, "_win_data"},  int'(win_data), 0);
    check({tag, "_win_x"},     int'(win_x), 0);
    check({tag, "_win_y"},     int'(win_y), 0);
    check({tag, "_mem_x"},     int'(mem_x), 0);
    check({tag, "_mem_y"},     int'(mem_y), 0);
    check({tag, "_mem_write"}, int'(mem_write), 0);
  endtask

  typedef struct {
    int         pat;
    int         cx;
    int         cy;
    logic [8:0] exp;
  } vec_t;

  vec_t vecs [12];

  task automatic checkTable(input int pat);
    for (int i = 0; i < 12; i++)
      if (vecs[i].pat == pat)
        check($sformatf("win_p%0d_(%0d,%0d)", pat, vecs[i].cx, vecs[i].cy),
              int'(winRec[vecs[i].cy*W + vecs[i].cx]), int'(vecs[i].exp));
  endtask

  initial begin
    int c, cyc, base, baseDone, nx, ny;

    vecs[0]  = '{0, 0, 0, 9'h1B0};
    vecs[1]  = '{0, 1, 1, 9'h1FF};
    vecs[2]  = '{0, 3, 2, 9'h01B};
    vecs[3]  = '{0, 1, 0, 9'h1F8};
    vecs[4]  = '{0, 3, 0, 9'h0D8};
    vecs[5]  = '{0, 0, 2, 9'h036};
    vecs[6]  = '{1, 1, 0, 9'h100};
    vecs[7]  = '{1, 2, 1, 9'h010};
    vecs[8]  = '{1, 3, 2, 9'h001};
    vecs[9]  = '{1, 2, 0, 9'h080};
    vecs[10] = '{1, 3, 1, 9'h008};
    vecs[11] = '{1, 0, 0, 9'h000};

    setMem(0);
    for (int i = 0; i < W*H; i++) winRec[i] = '0;

    // Reset held, then idle with no start.
    repeat (3) @(negedge clk);
    checkResetOutputs("rst");
    reset = 1'b1;
    repeat (5) @(negedge clk);
    checkResetOutputs("idle");

    // Frame 1: all ones, always ready, with a stray start mid-frame.
    win_ready = 1'b1;
    base = winCount;
    baseDone = doneCount;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    c = 1;
    check("f1_busy_cycle1", int'(busy), 1);
    while (!done && c < 300) begin
      @(negedge clk);
      c++;
      if (c == 30) start = 1'b1;
      else if (c == 31) start = 1'b0;
    end
    check("f1_done_cycle", c, 12*11 + 1);
    check("f1_busy_at_done", int'(busy), 0);
    @(negedge clk);
    check("f1_done_single", int'(done), 0);
    check("f1_win_count", winCount - base, 12);
    check("f1_done_count", doneCount - baseDone, 1);
    checkTable(0);

    // Frame 2: single one at (2,1); cycle-exact address and latency check.
    setMem(1);
    repeat (2) @(negedge clk);
    base = winCount;
    baseDone = doneCount;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int p = 0; p < W*H; p++) begin
      for (int k = 0; k < 9; k++) begin
        nbr(p % W, p / W, k, nx, ny);
        check($sformatf("addr_x_p%0d_k%0d", p, k), int'(mem_x), nx);
        check($sformatf("addr_y_p%0d_k%0d", p, k), int'(mem_y), ny);
        @(negedge clk);
      end
      check($sformatf("drain_valid_p%0d", p), int'(win_valid), 0);
      @(negedge clk);
      check($sformatf("present_valid_p%0d", p), int'(win_valid), 1);
      check($sformatf("present_x_p%0d", p), int'(win_x), p % W);
      check($sformatf("present_y_p%0d", p), int'(win_y), p / W);
      check($sformatf("present_data_p%0d", p), int'(win_data), int'(modelWin(p % W, p / W)));
      if (p == 1*W + 2) check("centre_bit", int'(win_data[CENTRE_BIT]), 1);
      @(negedge clk);
    end
    check("f2_done", int'(done), 1);
    check("f2_busy_at_done", int'(busy), 0);
    @(negedge clk);
    check("f2_win_count", winCount - base, 12);
    check("f2_done_count", doneCount - baseDone, 1);
    checkTable(1);

    // Frame 3: backpressure while presenting (1,1).
    win_ready = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int w = 0; w < 6; w++) begin
      waitValid(20, cyc);
      if (w < 5) begin
        win_ready = 1'b1;
        @(negedge clk);
        win_ready = 1'b0;
      end
    end
    check("bp_win_x", int'(win_x), 1);
    check("bp_win_y", int'(win_y), 1);
    base = winCount;
    for (int i = 0; i < 20; i++) begin
      check("bp_valid_hold", int'(win_valid), 1);
      check("bp_data_hold", int'(win_data), 9'h020);
      check("bp_mem_x_hold", int'(mem_x), 2);
      check("bp_mem_y_hold", int'(mem_y), 2);
      @(negedge clk);
    end
    check("bp_no_accept", winCount - base, 0);
    win_ready = 1'b1;
    @(negedge clk);
    win_ready = 1'b0;
    check("bp_valid_drop", int'(win_valid), 0);
    check("bp_one_accept", winCount - base, 1);

    // Reset asserted in the middle of the next FETCH.
    repeat (2) @(negedge clk);
    check("mid_fetch_busy", int'(busy), 1);
    reset = 1'b0;
    #1;
    checkResetOutputs("async_rst");
    @(negedge clk);
    reset = 1'b1;
    setMem(0);
    repeat (2) @(negedge clk);

    // Fresh frame after reset starts at (0,0).
    base = winCount;
    baseDone = doneCount;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitValid(30, cyc);
    check("restart_latency", cyc + 1, 11);
    check("restart_win_x", int'(win_x), 0);
    check("restart_win_y", int'(win_y), 0);
    check("restart_win_data", int'(win_data), 9'h1B0);
    win_ready = 1'b1;
    c = 0;
    while (!done && c < 300) begin
      @(negedge clk);
      c++;
    end
    check("restart_done_seen", int'(done), 1);
    @(negedge clk);
    check("restart_win_count", winCount - base, 12);
    check("restart_done_count", doneCount - baseDone, 1);
    check("restart_busy_end", int'(busy), 0);
    check("mem_write_never", int'(memWriteSeen), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/window_fetch_reader.md
Name: window_fetch_reader

Overview:
- Read-side master for the binary frame memory. On start, raster-scans the whole image and reads the 3x3 neighbourhood of every pixel through the memory's x/y address port.
- Presents each neighbourhood as a 9-bit window with a valid/ready handshake to the median filter core.
- Owns the memory port only while busy. Never writes.

Parameters:
- IMWIDTH, 240, image width in pixels.
- IMHEIGHT, 180, image height in pixels.
- ADDR_W, 8, width of the x and y coordinates. Must satisfy 2^ADDR_W >= max(IMWIDTH, IMHEIGHT).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request to begin a frame scan. Sampled only in IDLE.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse after the last window is accepted.
- mem_x  out  ADDR_W  memory x address.
- mem_y  out  ADDR_W  memory y address.
- mem_write  out  1  memory write enable. Constant 0.
- mem_data  in  1  memory read data. Registered; valid one cycle after the address.
- win_data  out  9  window bits. Bit k = (dy+1)*3 + (dx+1), for dy,dx in {-1,0,1}. Bit 4 is the centre pixel.
- win_x  out  ADDR_W  centre x coordinate of the presented window.
- win_y  out  ADDR_W  centre y coordinate of the presented window.
- win_valid  out  1  window valid.
- win_ready  in  1  consumer accepts the window.

Behaviour:
- Reset values: busy=0, done=0, win_valid=0, win_data=0, win_x=0, win_y=0, mem_x=0, mem_y=0, mem_write=0. State is IDLE; fetch index k=0.
- States: IDLE, FETCH, DRAIN, PRESENT, DONE.
- IDLE:
  - start=1 -> FETCH, with centre (0,0) and k=0.
  - start=0 -> stay in IDLE.
- FETCH:
  - Issue neighbour k in each cycle, k = 0..8.
  - Neighbour coordinates are centre + (dx,dy), computed in ADDR_W+1 signed bits.
  - A neighbour is out of bounds (OOB) if either coordinate is < 0, x >= IMWIDTH, or y >= IMHEIGHT.
  - OOB neighbour: drive the centre address and pipeline an oob flag with k.
  - After k=8 -> DRAIN.
- Capture:
  - The neighbour issued in cycle t is captured at the end of cycle t+1.
  - win_data[k] = oob ? 0 : mem_data.
  - The DRAIN cycle captures k=8.
- DRAIN -> PRESENT. In PRESENT, win_valid=1 and win_x/win_y hold the centre.
- PRESENT:
  - win_valid, win_data, win_x and win_y are held stable while win_ready=0.
  - Accept occurs when win_valid & win_ready.
  - On accept with more pixels remaining: advance the centre in raster order (x+1; on x = IMWIDTH-1, wrap x to 0 and increment y) -> FETCH.
  - On accept of the last pixel (IMWIDTH-1, IMHEIGHT-1) -> DONE.
  - win_valid drops in the cycle after accept.
- DONE: done=1 for one cycle, busy=0 in the same cycle -> IDLE.
- Timing, with start high in cycle 0:
  - Neighbour k=0 is issued in cycle 1.
  - DRAIN is cycle 10.
  - win_valid=1 from cycle 11.
  - With win_ready held at 1, each pixel takes 11 cycles, giving a frame of IMWIDTH*IMHEIGHT*11 cycles.
- start while busy is ignored: no restart and no glitch.
- Reset asserted mid-scan: all outputs return to reset values immediately. A later start begins a fresh frame at (0,0).
- mem_x and mem_y hold their last value outside FETCH.

Decomposition:
- Shared package holds:
  - IMWIDTH, IMHEIGHT and ADDR_W defaults, shared with the frame memory.
  - The state encoding.
  - The window bit-index constant CENTRE_BIT=4.
- One natural sub-module, neighbour_addr_gen. It is combinational and maps centre + k to (x, y, oob).

Test Plan:
- Reset with no start: all outputs at reset values; mem_write stays 0 for the entire run; busy=0.
- IMWIDTH=4, IMHEIGHT=3, all-ones memory model, win_ready=1:
  - Windows in raster order: (0,0) -> 0x1B0, (1,1) -> 0x1FF, (3,2) -> 0x01B.
  - Exactly 12 windows; done pulses once; busy drops.
- Single 1 at (2,1), 4x3 image: the windows centred at (1,0), (2,1) and (3,2) show that bit at k=8, k=4 and k=0 respectively. The bench checks all addresses issued, with OOB cycles driving the centre address.
- Latency: start in cycle 0 -> first win_valid in cycle 11. The next win_valid comes 11 cycles after each accept.
- Backpressure: win_ready=0 for 20 cycles while presenting (1,1). win_valid and win_data stay stable, and no memory address changes occur. Raising win_ready accepts exactly one window.
- start pulsed mid-frame: ignored, and the window count stays at 12. Reset asserted mid-FETCH: outputs reset asynchronously. A new start produces the first window at (0,0).
